uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, clken ticks per bit period; legal values are even numbers from 8 to 16.
REQ-002 clk_50m  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 clken  input  1  oversample tick, one clk_50m cycle wide, at OVERSAMPLE x baud rate.
REQ-005 rx  input  1  serial data line, asynchronous; idles high.
REQ-006 dout  output  8  last correctly received byte.
REQ-007 dout_valid  output  1  one-cycle strobe when dout updates; doubles as the FIFO write flag.
REQ-008 frame_err  output  1  one-cycle strobe when the stop bit samples low.
REQ-009 rx_busy  output  1  high whenever state != IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all rx decisions use only the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP and BRK; the tick counter (4 bit) and the bit counter (3 bit) change only on clken.
REQ-012 IDLE: when clken=1 and rx_s=0, go to START and clear the tick counter; otherwise stay.
REQ-013 START: when the tick counter reaches OVERSAMPLE/2-1, sample rx_s at mid-bit.
- Sample 1 (glitch): return to IDLE, no strobes.
- Sample 0: go to DATA, clear both counters.
REQ-014 DATA: every OVERSAMPLE ticks, sample rx_s at mid-bit into shift bit[bitcnt], LSB first.
- After bit 7, go to STOP and clear the tick counter.
REQ-015 STOP: after OVERSAMPLE ticks, sample rx_s.
- Sample 1: load dout from the shift register, pulse dout_valid for exactly one clk_50m cycle, go to IDLE.
- Sample 0: pulse frame_err for one cycle, leave dout unchanged, go to BRK.
REQ-016 BRK: stay until a clken with rx_s=1, then go to IDLE; a held-low line SHALL yield exactly one frame_err.
REQ-017 Latency: dout_valid or frame_err SHALL assert on the clk_50m edge immediately after the mid-stop-bit clken edge.
REQ-018 dout_valid and frame_err SHALL never assert in the same cycle.
REQ-019 A new start bit SHALL be accepted on the first clken after return to IDLE, allowing back-to-back frames with one stop bit.
REQ-020 With clken=0, all state, counters and outputs SHALL hold, apart from the synchronizer and the one-cycle strobe deassertion.
REQ-021 Counter arithmetic SHALL be unsigned modulo the counter width; the tick counter clears on every bit-boundary sample.

Reset
REQ-022 While rst_n=0, the following SHALL hold their reset values:
- state=IDLE, counters=0, shift register=8'h00;
- dout=8'h00, dout_valid=0, frame_err=0, rx_busy=0;
- synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no dout_valid or frame_err.
REQ-024 After rst_n deasserts, reception SHALL restart only on a fresh falling edge of rx_s.

Structure
REQ-025 A shared package uart_pkg SHALL hold:
- the state encoding constants (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, BRK=3'b100);
- the OVERSAMPLE default;
- the data width 8.
REQ-026 The synchronizer SHALL be a separate sub-module uart_sync2 (1-bit, reset value 1); all other logic resides in uart_rx.

Verification
REQ-027 Frame 0xA5 at OVERSAMPLE=16, clken every 27 clocks, ideal timing -> exactly one dout_valid with dout=8'hA5 and frame_err=0.
REQ-028 Back-to-back frames 0x00 then 0xFF with no idle gap -> two dout_valid strobes, dout=8'h00 then 8'hFF.
REQ-029 rx low for 4 ticks, then high -> no strobes; rx_busy returns low by tick 8.
REQ-030 Frame 0x3C with stop bit forced 0 and rx held low for 3 bit times -> one frame_err; dout keeps its prior value; no dout_valid; BRK exits after rx goes high.
REQ-031 rst_n pulsed low during data bit 4 of 0x81 -> outputs at reset values, no strobe; the next clean frame 0x5A is received correctly.
REQ-032 Frame 0x96 with bit edges jittered by ±3 ticks -> dout=8'h96 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, widths and
// the default oversampling ratio.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned TICK_W         = 4;
  localparam int unsigned BIT_W          = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b011,
    BRK   = 3'b100
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// the line's idle level (high).
module uart_sync2 (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 framing, LSB first, mid-bit sampling, with
// frame-error detection and a break state that absorbs a held-low line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              clken,
  input  logic              rx,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_d;
  logic              valid_d, err_d;
  logic              armed_q, armed_d;
  logic              rx_s;

  uart_sync2 u_sync (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .d       (rx),
    .q       (rx_s)
  );

  // The synchronizer resets to 1, so a line still low when reset releases
  // would look like a start bit; armed requires a high sample first.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout;
    valid_d = 1'b0;
    err_d   = 1'b0;
    armed_d = armed_q;

    if (clken) begin
      if (rx_s) armed_d = 1'b1;

      unique case (state_q)
        IDLE: begin
          if (!rx_s && armed_q) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        START: begin
          if (tick_q == HALF_LAST) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_q == FULL_LAST) begin
            tick_d         = '0;
            shift_d[bit_q] = rx_s;
            bit_d          = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        STOP: begin
          if (tick_q == FULL_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BRK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        BRK: begin
          if (rx_s) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      frame_err  <= err_d;
      armed_q    <= armed_d;
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are built from bytes and bit-edge
// jitter, and received strobes are scored against a frame-level event queue.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       rx_busy;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned n_vec       = 0;
  int unsigned n_miss      = 0;
  int unsigned n_exp       = 0;
  int unsigned n_obs       = 0;
  int unsigned tick_period = 27;
  logic [7:0]  last_good   = 8'h00;
  logic        ce_at_edge  = 1'b0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .clken      (clken),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  initial forever begin
    repeat (tick_period - 1) @(negedge clk_50m);
    clken = 1'b1;
    @(negedge clk_50m);
    clken = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) begin
      do @(posedge clk_50m); while (clken !== 1'b1);
      #1;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    tick_wait(n);
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    if (stop_ok) begin
      e.err     = 1'b0;
      e.data    = b;
      last_good = b;
    end else begin
      e.err  = 1'b1;
      e.data = last_good;
    end
    exp_q.push_back(e);
    n_exp++;
  endtask

  // e[k] is the offset of the edge that starts bit k (0 = start bit).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int jit);
    int e[10];
    expect_frame(b, stop_ok);
    e[0] = 0;
    for (int k = 1; k < 10; k++)
      e[k] = (jit == 0) ? 0 : int'($urandom_range(2 * jit, 0)) - jit;
    drive(1'b0, OS + e[1] - e[0]);
    for (int i = 0; i < 8; i++) drive(b[i], OS + e[i + 2] - e[i + 1]);
    drive(stop_ok, OS - e[9]);
  endtask

  always @(posedge clk_50m) ce_at_edge <= clken;

  always @(negedge clk_50m) begin
    ev_t e;
    if (rst_n && (dout_valid || frame_err)) begin
      n_obs++;
      chk("exclusive", {31'd0, dout_valid & frame_err}, 32'd0);
      chk("latency", {31'd0, ce_at_edge}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("kind", {31'd0, frame_err}, {31'd0, e.err});
        chk("dout", {24'd0, dout}, {24'd0, e.data});
      end
    end
  end

  initial begin
    logic [7:0] b;
    bit         ok;

    repeat (5) @(negedge clk_50m);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 4);

    send_frame(8'hA5, 1'b1, 0);
    drive(1'b1, 4);
    chk("a5_count", n_obs, n_exp);
    chk("a5_dout", {24'd0, dout}, 32'h0000_00A5);

    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    drive(1'b1, 4);
    chk("b2b_count", n_obs, n_exp);
    chk("b2b_dout", {24'd0, dout}, 32'h0000_00FF);

    drive(1'b0, 4);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, 5);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    chk("glitch_count", n_obs, n_exp);

    send_frame(8'h3C, 1'b0, 0);
    drive(1'b0, 3 * OS);
    chk("brk_busy", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, 1);
    chk("brk_exit", {31'd0, rx_busy}, 32'd0);
    drive(1'b1, 4);
    chk("brk_count", n_obs, n_exp);
    chk("brk_dout", {24'd0, dout}, 32'h0000_00FF);

    b = 8'h81;
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(b[i], OS);
    drive(b[4], OS / 2);
    @(negedge clk_50m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("mid_rst_strobe", {30'd0, dout_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    last_good = 8'h00;
    drive(b[4], OS / 2);
    for (int i = 5; i < 8; i++) drive(b[i], OS);
    drive(1'b1, OS + 20);
    chk("abort_count", n_obs, n_exp);
    chk("abort_dout", {24'd0, dout}, 32'd0);

    send_frame(8'h5A, 1'b1, 0);
    drive(1'b1, 4);
    chk("5a_count", n_obs, n_exp);
    chk("5a_dout", {24'd0, dout}, 32'h0000_005A);

    send_frame(8'h96, 1'b1, 3);
    drive(1'b1, 4);
    chk("jit_count", n_obs, n_exp);
    chk("jit_dout", {24'd0, dout}, 32'h0000_0096);

    tick_period = 5;
    drive(1'b1, 2);
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(4, 0) != 0);
      send_frame(b, ok, int'($urandom_range(3, 0)));
      if (!ok) drive(1'b0, int'($urandom_range(2 * OS, 0)));
      if (!ok || $urandom_range(1, 0) == 1) drive(1'b1, int'($urandom_range(6, 1)));
    end
    drive(1'b1, 4);
    chk("rand_count", n_obs, n_exp);
    chk("rand_pending", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
